fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences the combinational instruction memory (byte address in, 32-bit word out, one instruction per 4 bytes). It drives the memory address every cycle and captures the returned word into an IF register with a valid flag. It supports start, halt, stall and branch/jump redirect, and traps misaligned or out-of-range fetches. It sits between the instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the combinational
// instruction memory address and captures the returned word into the IF
// register. Handles start/halt/stall/redirect and traps bad fetch addresses.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [31:0] LIMIT = 32'(IMEM_BYTES);

  state_t      cur, nxt;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_n, instr_pc_n;
  logic        valid_n, fault_n;
  logic        redirect_bad;

  assign imem_addr    = pc;
  assign state        = cur;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= LIMIT);

  // State and IF-register update; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur         <= nxt;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
      fault       <= fault_n;
    end
  end

  // Next-state and datapath selection: halt > redirect > stall > range > fetch.
  always_comb begin
    nxt        = cur;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    fault_n    = fault;
    case (cur)
      IDLE: begin
        valid_n = 1'b0;
        if (start) nxt = FETCH;
      end
      FETCH: begin
        if (halt_req) begin
          nxt     = HALT;
          valid_n = 1'b0;
        end else if (redirect) begin
          valid_n = 1'b0;
          if (redirect_bad) begin
            nxt     = FAULT;
            fault_n = 1'b1;
          end else begin
            pc_n = redirect_pc;
          end
        end else if (stall) begin
          // hold everything
        end else if (pc >= LIMIT) begin
          nxt     = FAULT;
          fault_n = 1'b1;
          valid_n = 1'b0;
        end else begin
          instr_n    = imem_rd;
          instr_pc_n = pc;
          valid_n    = 1'b1;
          pc_n       = pc + 32'd4;
        end
      end
      HALT: begin
        valid_n = 1'b0;
        if (start) nxt = FETCH;
      end
      FAULT: begin
        valid_n = 1'b0;
        fault_n = 1'b1;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with a combinational memory model.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  state;

  logic [31:0] mem [0:63];
  int unsigned vectors;
  int unsigned miscompares;

  fetch_sequencer #(.RESET_PC(32'd0), .IMEM_BYTES(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fault       (fault),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 32'd256) imem_rd = mem[imem_addr[7:2]];
    else                     imem_rd = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_state"}, {30'd0, state}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_ipc"},   instr_pc, 32'h0);
  endtask

  // Reset mid-cycle, then leave it and start fetching from RESET_PC.
  task automatic restart();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    reset = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; halt_req = 1'b0;

    #1 reset = 1'b1;
    #1 check_reset_values("rst");
    tick();
    check("rst_hold_state", {30'd0, state}, 32'd0);
    reset = 1'b0;

    // Start and sequential fetch
    start = 1'b1;
    tick();                                    // edge 1: IDLE->FETCH
    start = 1'b0;
    check("e1_state", {30'd0, state}, 32'd1);
    check("e1_valid", {31'd0, instr_valid}, 32'd0);
    check("e1_addr",  imem_addr, 32'd0);
    tick();                                    // edge 2: fetch 0
    check("e2_valid", {31'd0, instr_valid}, 32'd1);
    check("e2_instr", instr, 32'h2008_0005);
    check("e2_ipc",   instr_pc, 32'd0);
    check("e2_addr",  imem_addr, 32'd4);
    tick();                                    // edge 3: fetch 4
    check("e3_instr", instr, 32'h2009_0003);
    check("e3_ipc",   instr_pc, 32'd4);
    check("e3_addr",  imem_addr, 32'd8);

    // Stall three cycles at pc=8
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("stall_addr",  imem_addr, 32'd8);
      check("stall_instr", instr, 32'h2009_0003);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("unstall_ipc",   instr_pc, 32'd8);
    check("unstall_instr", instr, 32'hA000_0002);
    check("unstall_addr",  imem_addr, 32'd12);

    // Redirect to 0x40 at pc=12, with a stall that must be overridden
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_addr",  imem_addr, 32'h40);
    tick();
    check("redir_tgt_valid", {31'd0, instr_valid}, 32'd1);
    check("redir_tgt_ipc",   instr_pc, 32'h40);
    check("redir_tgt_instr", instr, 32'hA000_0010);

    // Move to pc=0x10, then halt
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    check("to10_addr", imem_addr, 32'h10);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_state", {30'd0, state}, 32'd2);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_addr",  imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h80;     // ignored in HALT
    tick();
    redirect = 1'b0;
    check("halt_redir_addr",  imem_addr, 32'h10);
    check("halt_redir_state", {30'd0, state}, 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_state", {30'd0, state}, 32'd1);
    tick();
    check("resume_ipc",   instr_pc, 32'h10);
    check("resume_instr", instr, 32'hA000_0004);
    check("resume_valid", {31'd0, instr_valid}, 32'd1);

    // halt_req together with redirect: halt wins, pc unchanged
    halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    halt_req = 1'b0; redirect = 1'b0;
    check("haltredir_state", {30'd0, state}, 32'd2);
    check("haltredir_addr",  imem_addr, 32'h14);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("haltredir_ipc", instr_pc, 32'h14);

    // Misaligned redirect faults; start has no effect
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    check("mis_state", {30'd0, state}, 32'd3);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    check("mis_addr",  imem_addr, 32'h18);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("mis_start_state", {30'd0, state}, 32'd3);
    check("mis_start_fault", {31'd0, fault}, 32'd1);

    // Out-of-range redirect faults
    restart();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("oor_state", {30'd0, state}, 32'd3);
    check("oor_fault", {31'd0, fault}, 32'd1);
    check("oor_addr",  imem_addr, 32'h0);

    // Last legal word, then range fault on the following edge
    restart();
    redirect = 1'b1; redirect_pc = 32'hFC;
    tick();
    redirect = 1'b0;
    tick();
    check("last_ipc",   instr_pc, 32'hFC);
    check("last_instr", instr, 32'hA000_003F);
    check("last_valid", {31'd0, instr_valid}, 32'd1);
    check("last_addr",  imem_addr, 32'h100);
    check("last_state", {30'd0, state}, 32'd1);
    tick();
    check("end_state", {30'd0, state}, 32'd3);
    check("end_fault", {31'd0, fault}, 32'd1);
    check("end_valid", {31'd0, instr_valid}, 32'd0);

    // Asynchronous reset mid-clock while fetching at pc=0x20
    restart();
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    check("pre_arst_addr", imem_addr, 32'h20);
    tick();
    check("pre_arst_valid", {31'd0, instr_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("arst");
    tick();
    reset = 1'b0;
    tick();
    check("post_arst_state", {30'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
